fetch_unit: RTL and testbench

Instruction fetch stage of the multicycle RISC-V core, directly upstream of the control unit. Holds the program counter and instruction register, runs a request/acknowledge read on instruction memory when the control unit requests a fetch, and presents the latched instruction (and its opcode field) to the control unit and datapath. Performs the PC update (sequential or immediate-relative) on the control unit's strobe.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage holding PC and IR for the multicycle RISC-V core.
//   clk, rst_n (sync, active-high)   : clock and reset
//   fetch_req, pc_update, pc_src, imm : control-unit strobes and PC-update selection
//   i_mem_req/addr/ack/data           : request/acknowledge instruction memory read port
//   ir, opcode, ir_valid, fetch_busy  : latched instruction and fetch status
//   misaligned_fault                  : sticky flag, set when a PC target is not word aligned
module fetch_unit #(
   parameter int                     PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_req,
   input  logic                pc_update,
   input  logic                pc_src,
   input  logic [PC_WIDTH-1:0] imm,
   output logic                i_mem_req,
   output logic [PC_WIDTH-1:0] i_mem_addr,
   input  logic                i_mem_ack,
   input  logic [31:0]         i_mem_data,
   output logic [31:0]         ir,
   output logic [6:0]          opcode,
   output logic                ir_valid,
   output logic                fetch_busy,
   output logic                misaligned_fault
);
   typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;
   state_t              state;
   logic [PC_WIDTH-1:0] pc, pend_imm, upd_imm, tgt;
   logic                pend, pend_src, upd_src, apply;
   // An update deferred during REQ is only ever pending in VALID, the cycle after ack,
   // where it takes priority over any new strobe.
   always_comb begin
      upd_src = pend ? pend_src : pc_src;
      upd_imm = pend ? pend_imm : imm;
      tgt     = pc + (upd_src ? upd_imm : PC_WIDTH'(4));
      apply   = (state == IDLE || state == VALID) && (pend || pc_update);
   end
   assign i_mem_addr = pc;
   assign opcode     = ir[6:0];
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state            <= IDLE;
         pc               <= RESET_PC;
         ir               <= 32'h0000_0013;
         ir_valid         <= 1'b0;
         i_mem_req        <= 1'b0;
         fetch_busy       <= 1'b0;
         misaligned_fault <= 1'b0;
         pend             <= 1'b0;
         pend_src         <= 1'b0;
         pend_imm         <= '0;
      end else begin
         case (state)
            IDLE, VALID: begin
               if (apply) begin
                  pend     <= 1'b0;
                  ir_valid <= 1'b0;
                  if (|tgt[1:0]) begin
                     misaligned_fault <= 1'b1;
                     state            <= FAULT;
                  end else begin
                     pc    <= tgt;
                     state <= IDLE;
                  end
               end else if (fetch_req) begin
                  state      <= REQ;
                  ir_valid   <= 1'b0;
                  i_mem_req  <= 1'b1;
                  fetch_busy <= 1'b1;
               end
            end
            REQ: begin
               if (pc_update) begin
                  pend     <= 1'b1;
                  pend_src <= pc_src;
                  pend_imm <= imm;
               end
               if (i_mem_ack) begin
                  ir         <= i_mem_data;
                  ir_valid   <= 1'b1;
                  i_mem_req  <= 1'b0;
                  fetch_busy <= 1'b0;
                  state      <= VALID;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a PC/IR reference model.
module tb_fetch_unit;
   localparam int W = 64;
   logic          clk = 1'b0, rst_n = 1'b1, fetch_req = 1'b0, pc_update = 1'b0, pc_src = 1'b0;
   logic [W-1:0]  imm = '0;
   logic          i_mem_req, i_mem_ack = 1'b0;
   logic [W-1:0]  i_mem_addr;
   logic [31:0]   i_mem_data = '0, ir;
   logic [6:0]    opcode;
   logic          ir_valid, fetch_busy, misaligned_fault;

   always #5 clk = ~clk;

   fetch_unit #(.PC_WIDTH(W), .RESET_PC('0)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_update(pc_update), .pc_src(pc_src),
      .imm(imm), .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr), .i_mem_ack(i_mem_ack),
      .i_mem_data(i_mem_data), .ir(ir), .opcode(opcode), .ir_valid(ir_valid),
      .fetch_busy(fetch_busy), .misaligned_fault(misaligned_fault)
   );

   int           n_cmp = 0, n_fail = 0;
   logic [31:0]  exp_q[$];
   logic [W-1:0] addr_q[$];
   logic [W-1:0] m_pc = '0;
   logic         m_fault = 1'b0;
   logic [31:0]  m_ir = 32'h13;
   logic         auto_en = 1'b1, man_ack = 1'b0;
   logic [31:0]  man_data = '0;

   function automatic logic [31:0] mem(input logic [W-1:0] a);
      return (a == 0) ? 32'h0050_0093 : ((a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13);
   endfunction

   function automatic logic [W-1:0] rimm();
      logic [W-1:0] v;
      v = $urandom_range(0, 1) ? {$urandom, $urandom} : W'($signed(32'($urandom_range(0, 64)) - 32));
      return v & ~64'h3;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory: random 0..3 wait states while requested, stray acks with junk data otherwise
   initial begin
      int wl = -1;
      forever begin
         tick();
         if (!auto_en) begin
            i_mem_ack  = man_ack;
            i_mem_data = man_data;
            wl = -1;
         end else if (i_mem_req) begin
            if (wl < 0) wl = $urandom_range(0, 3);
            if (wl == 0) begin
               i_mem_ack  = 1'b1;
               i_mem_data = mem(i_mem_addr);
               wl = -1;
            end else begin
               i_mem_ack = 1'b0;
               wl--;
            end
         end else begin
            i_mem_ack  = ($urandom_range(0, 7) == 0);
            i_mem_data = 32'hBAD0_BAD0;
            wl = -1;
         end
      end
   end

   // monitor: checks request stability and pops the expected word on each new ir_valid
   initial begin
      logic        pv = 1'b0;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (i_mem_req) begin
            if (addr_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL req_unexpected: got addr %h expected no request", i_mem_addr);
            end else chk("req_addr", i_mem_addr, addr_q[0]);
            chk("busy", W'(fetch_busy), 1);
         end
         if (ir_valid && !pv) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL ir_unexpected: got %h expected no instruction", ir);
            end else begin
               e = exp_q.pop_front();
               void'(addr_q.pop_front());
               chk("ir", W'(ir), W'(e));
               chk("opcode", W'(opcode), W'(e[6:0]));
            end
         end
         pv = ir_valid;
      end
   end

   task automatic model_upd(input logic s, input logic [W-1:0] im);
      logic [W-1:0] t;
      if (m_fault) return;
      t = s ? m_pc + im : m_pc + 4;
      if (t[1:0] != 0) m_fault = 1'b1;
      else m_pc = t;
   endtask

   task automatic chk_state();
      chk("pc", i_mem_addr, m_pc);
      chk("fault", W'(misaligned_fault), W'(m_fault));
      chk("ir_valid", W'(ir_valid), 0);
      chk("ir_hold", W'(ir), W'(m_ir));
      chk("req_idle", W'(i_mem_req), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      fetch_req = 1'b0;
      pc_update = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      addr_q.delete();
      m_pc = '0;
      m_fault = 1'b0;
      m_ir = 32'h13;
   endtask

   task automatic update(input logic s, input logic [W-1:0] im);
      pc_update = 1'b1;
      pc_src = s;
      imm = im;
      fetch_req = 1'($urandom_range(0, 1));
      tick();
      pc_update = 1'b0;
      fetch_req = 1'b0;
      model_upd(s, im);
      chk_state();
   endtask

   task automatic fetch(input logic extra, input logic upd, input logic us, input logic [W-1:0] ui);
      logic got = 1'b0;
      exp_q.push_back(mem(m_pc));
      addr_q.push_back(m_pc);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      if (upd) begin
         pc_update = 1'b1;
         pc_src = us;
         imm = ui;
         tick();
         pc_update = 1'b0;
         pc_src = 1'($urandom);
         imm = {$urandom, $urandom} | 64'h1;
      end
      for (int i = 0; i < 20; i++) begin
         if (ir_valid) begin
            got = 1'b1;
            break;
         end
         fetch_req = extra && ($urandom_range(0, 1) == 1);
         tick();
         fetch_req = 1'b0;
      end
      chk("fetch_done", W'(got), 1);
      m_ir = mem(m_pc);
      if (upd) begin
         tick();
         model_upd(us, ui);
         chk_state();
      end
   endtask

   initial begin
      do_reset();
      chk("rst_ir", W'(ir), 64'h13);
      chk("rst_opcode", W'(opcode), 64'h13);
      chk("rst_ir_valid", W'(ir_valid), 0);
      chk("rst_req", W'(i_mem_req), 0);
      chk("rst_busy", W'(fetch_busy), 0);
      chk("rst_fault", W'(misaligned_fault), 0);
      chk("rst_pc", i_mem_addr, 0);
      // zero-wait fetch: valid two edges after fetch_req
      auto_en = 1'b0;
      man_ack = 1'b1;
      man_data = 32'h0050_0093;
      exp_q.push_back(32'h0050_0093);
      addr_q.push_back(0);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("first_req", W'(i_mem_req), 1);
      chk("first_ir_valid_early", W'(ir_valid), 0);
      tick();
      chk("first_ir_valid", W'(ir_valid), 1);
      chk("first_ir", W'(ir), 64'h0050_0093);
      chk("first_busy", W'(fetch_busy), 0);
      chk("first_req_drop", W'(i_mem_req), 0);
      m_ir = 32'h0050_0093;
      man_ack = 1'b0;
      auto_en = 1'b1;
      update(1'b0, '0);
      update(1'b1, -64'sd8);
      chk("wrap_pc", i_mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      for (int n = 0; n < 150; n++) begin
         int r = $urandom_range(0, 9);
         if (r < 4) fetch(1'b1, 1'b0, 1'b0, '0);
         else if (r < 7) fetch(1'b1, 1'b1, 1'($urandom), rimm());
         else update(1'($urandom), rimm());
      end
      // update deferred during a fetch at PC 0x20
      do_reset();
      for (int n = 0; n < 8; n++) update(1'b0, '0);
      fetch(1'b0, 1'b1, 1'b0, '0);
      chk("pend_pc", i_mem_addr, 64'h24);
      // misaligned target faults and is sticky until reset
      do_reset();
      for (int n = 0; n < 4; n++) update(1'b0, '0);
      update(1'b1, 64'h6);
      chk("mis_pc", i_mem_addr, 64'h10);
      chk("mis_fault", W'(misaligned_fault), 1);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      chk("fault_no_req", W'(i_mem_req), 0);
      chk("fault_no_busy", W'(fetch_busy), 0);
      update(1'b0, '0);
      do_reset();
      chk("fault_cleared", W'(misaligned_fault), 0);
      // reset during a request, late ack ignored
      auto_en = 1'b0;
      man_ack = 1'b0;
      exp_q.push_back(mem(0));
      addr_q.push_back(0);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      chk("hang_req", W'(i_mem_req), 1);
      do_reset();
      man_data = 32'hDEAD_BEEF;
      man_ack = 1'b1;
      tick();
      tick();
      man_ack = 1'b0;
      chk("late_ir", W'(ir), 64'h13);
      chk("late_req", W'(i_mem_req), 0);
      chk("late_valid", W'(ir_valid), 0);
      chk("late_pc", i_mem_addr, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
